// File: rtl/result_stream_reader.sv
// result_stream_reader: drains output_memory through its PL read port and streams the
// words out as valid/ready beats with a last flag, buffered by a 2-entry skid FIFO.
module result_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned CRD_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_rd_cnt;
    logic [LEN_W-1:0]      r_sent_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;

    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_busy;
    logic                  r_done;

    logic                  w_start_ok;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_last_beat;
    logic                  w_has_credit;
    logic                  w_can_issue;
    logic [CRD_W-1:0]      w_used;
    logic [CRD_W-1:0]      w_avail;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && m_tready;
    assign w_push      = r_inflight;
    assign w_last_beat = w_valid && (r_sent_cnt == (r_len - LEN_W'(1)));

    // Words buffered or in flight must stay below 2 plus whatever leaves this cycle
    assign w_used       = CRD_W'(r_count) + CRD_W'(r_inflight);
    assign w_avail      = CRD_W'(2) + CRD_W'(w_pop);
    assign w_has_credit = (w_used < w_avail);
    assign w_can_issue  = (r_rd_cnt < r_len) && w_has_credit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and read strobe
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                mem_en = w_can_issue;
                if (w_pop && w_last_beat) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: length, read/send counters, read address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_rd_cnt   <= '0;
            r_sent_cnt <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= mem_en;
            if (w_start_ok) begin
                r_len      <= len;
                r_addr     <= base_addr;
                r_rd_cnt   <= '0;
                r_sent_cnt <= '0;
            end else begin
                if (mem_en) begin
                    r_addr   <= r_addr + ADDR_WIDTH'(1);
                    r_rd_cnt <= r_rd_cnt + LEN_W'(1);
                end
                if (w_pop) begin
                    r_sent_cnt <= r_sent_cnt + LEN_W'(1);
                end
            end
        end
    end

    // Skid FIFO: captures read data one cycle after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= mem_dout;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status flags follow the next state so they line up with STREAM/FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_FINISH);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == CNT_W'(2))));

    assign mem_we   = 1'b0;
    assign mem_addr = r_addr;
    assign m_tdata  = r_fifo[r_rptr];
    assign m_tvalid = w_valid;
    assign m_tlast  = w_last_beat;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
